// File: rtl/bcd_conv_arbiter.sv
// bcd_conv_arbiter: round-robin arbiter sharing one iterative binary-to-BCD converter
// Optional abort on a stuck converter is enabled with `define ARB_TIMEOUT_EN.
module bcd_conv_arbiter #(
    parameter int N_REQ   = 4,
    parameter int BIN_W   = 8,
    parameter int BCD_W   = 16,
    parameter int TIMEOUT = 64
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N_REQ-1:0]       req,
    input  logic [N_REQ*BIN_W-1:0] req_data,
    output logic [N_REQ-1:0]       gnt,
    output logic [N_REQ-1:0]       done,
    output logic [BCD_W-1:0]       result,
    output logic                   busy,
    output logic                   conv_en,
    output logic [BIN_W-1:0]       conv_bin,
    input  logic                   conv_rdy,
    input  logic [BCD_W-1:0]       conv_bcd,
    output logic                   timeout
);
    localparam int PW = N_REQ > 1 ? $clog2(N_REQ) : 1;

    typedef enum logic [2:0] {IDLE, ISSUE, WAIT_LO, WAIT_HI, DONE} state_t;

    state_t           state;
    logic [PW-1:0]    rr_ptr;
    logic [PW-1:0]    win;
    logic [PW-1:0]    win_idx;
    logic [BIN_W-1:0] win_data;
    logic             found;
    int               idx;

`ifdef ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);
    logic [CW-1:0] wait_cnt;
    logic          expire;
    assign expire = wait_cnt == CW'(TIMEOUT - 1);
`else
    assign timeout = 1'b0;
`endif

    // first requester at or after rr_ptr, wrapping modulo N_REQ
    always_comb begin
        win_idx  = '0;
        win_data = '0;
        found    = 1'b0;
        idx      = 0;
        for (int i = 0; i < N_REQ; i++) begin
            idx = int'(rr_ptr) + i;
            if (idx >= N_REQ) idx = idx - N_REQ;
            if (!found && req[idx]) begin
                found    = 1'b1;
                win_idx  = PW'(idx);
                win_data = req_data[idx*BIN_W +: BIN_W];
            end
        end
    end

    // sequencer: grant, start converter, wait for rdy low then high, return result
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            rr_ptr   <= '0;
            win      <= '0;
            gnt      <= '0;
            done     <= '0;
            result   <= '0;
            busy     <= 1'b0;
            conv_en  <= 1'b0;
            conv_bin <= '0;
`ifdef ARB_TIMEOUT_EN
            wait_cnt <= '0;
            timeout  <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: if (found) begin
                    gnt      <= N_REQ'(1) << win_idx;
                    win      <= win_idx;
                    conv_bin <= win_data;
                    conv_en  <= 1'b1;
                    busy     <= 1'b1;
                    state    <= ISSUE;
                end
                ISSUE: begin
                    conv_en <= 1'b0;
`ifdef ARB_TIMEOUT_EN
                    wait_cnt <= '0;
`endif
                    state   <= WAIT_LO;
                end
                WAIT_LO: begin
`ifdef ARB_TIMEOUT_EN
                    wait_cnt <= wait_cnt + CW'(1);
                    if (expire) begin
                        result  <= '1;
                        done    <= gnt;
                        timeout <= 1'b1;
                        state   <= DONE;
                    end else
`endif
                    if (!conv_rdy) state <= WAIT_HI;
                end
                WAIT_HI: begin
`ifdef ARB_TIMEOUT_EN
                    wait_cnt <= wait_cnt + CW'(1);
`endif
                    if (conv_rdy) begin
                        result <= conv_bcd;
                        done   <= gnt;
                        state  <= DONE;
                    end
`ifdef ARB_TIMEOUT_EN
                    else if (expire) begin
                        result  <= '1;
                        done    <= gnt;
                        timeout <= 1'b1;
                        state   <= DONE;
                    end
`endif
                end
                DONE: begin
                    done   <= '0;
                    gnt    <= '0;
                    busy   <= 1'b0;
                    rr_ptr <= win == PW'(N_REQ - 1) ? '0 : win + PW'(1);
`ifdef ARB_TIMEOUT_EN
                    timeout <= 1'b0;
`endif
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_bcd_conv_arbiter.sv
// tb_bcd_conv_arbiter: directed bench with a 16-cycle converter model
module tb_bcd_conv_arbiter;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  req = '0;
    logic [31:0] req_data = '0;
    logic [3:0]  gnt, done;
    logic [15:0] result;
    logic        busy, conv_en, timeout;
    logic [7:0]  conv_bin;
    logic        conv_rdy = 1'b1;
    logic [15:0] conv_bcd = '0;

    int n_chk = 0, n_fail = 0;
    int en_cnt = 0, done_cnt = 0, to_cnt = 0, bad_oh = 0, bad_hold = 0, bad_done = 0;
    int stale = 0;
    bit stuck = 0;
    logic [7:0] m_bin = '0;
    int m_cnt = 0, m_delay = 0;
    bit m_act = 0;

    bcd_conv_arbiter dut (
        .clk(clk), .rst(rst), .req(req), .req_data(req_data), .gnt(gnt), .done(done),
        .result(result), .busy(busy), .conv_en(conv_en), .conv_bin(conv_bin),
        .conv_rdy(conv_rdy), .conv_bcd(conv_bcd), .timeout(timeout)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] to_bcd(input logic [7:0] b);
        int v;
        v = int'(b);
        return {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    // converter model: optional stale-rdy hold, 16 busy cycles, optional stuck-low
    always @(posedge clk) begin
        if (conv_en) begin
            m_bin    <= conv_bin;
            m_delay  <= stale;
            m_cnt    <= 16;
            m_act    <= 1'b1;
            conv_bcd <= 16'hDEAD;
        end else if (m_act) begin
            if (m_delay > 0) m_delay <= m_delay - 1;
            else if (m_cnt > 0) begin
                conv_rdy <= 1'b0;
                m_cnt    <= m_cnt - 1;
            end else if (!stuck) begin
                conv_rdy <= 1'b1;
                conv_bcd <= to_bcd(m_bin);
                m_act    <= 1'b0;
            end
        end
    end

    // protocol observers sampled mid-cycle
    always @(negedge clk) begin
        if (conv_en) en_cnt++;
        if (|done) done_cnt++;
        if (timeout) to_cnt++;
        if (!$onehot0(gnt)) bad_oh++;
        if (busy && gnt == '0) bad_hold++;
        if (!$onehot0(done) || (done & ~gnt) != '0) bad_done++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic wait_done(output int who, output logic [15:0] res, output int lat);
        who = -1;
        res = '0;
        lat = 0;
        for (int c = 1; c <= 200; c++) begin
            @(negedge clk);
            if (|done) begin
                for (int i = 0; i < 4; i++) if (done[i]) who = i;
                res = result;
                lat = c;
                break;
            end
        end
        if (who < 0) check("done_wait", 0, 1);
    endtask

    task automatic pulse_rst();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        int who, lat, e0, d0;
        logic [15:0] res;
        logic [7:0] vals [4];
        logic [15:0] exps [4];
        vals = '{8'd1, 8'd12, 8'd99, 8'd255};
        exps = '{16'h0001, 16'h0012, 16'h0099, 16'h0255};

        repeat (3) @(negedge clk);
        check("rst_gnt", gnt, 0);
        check("rst_done", done, 0);
        check("rst_result", result, 0);
        check("rst_busy", busy, 0);
        check("rst_conv_en", conv_en, 0);
        check("rst_conv_bin", conv_bin, 0);
        check("rst_timeout", timeout, 0);
        rst = 1'b0;
        @(negedge clk);

        e0 = en_cnt;
        req_data[7:0] = 8'd31;
        req = 4'b0001;
        @(negedge clk);
        check("single_gnt", gnt, 4'b0001);
        check("single_en", conv_en, 1);
        check("single_busy", busy, 1);
        check("single_bin", conv_bin, 8'd31);
        wait_done(who, res, lat);
        check("single_who", who, 0);
        check("single_res", res, 16'h0031);
        check("single_lat", lat, 19);
        check("single_gnt_done", gnt, 4'b0001);
        req = '0;
        @(negedge clk);
        check("single_en_cnt", en_cnt - e0, 1);
        check("single_idle_gnt", gnt, 0);
        check("single_idle_busy", busy, 0);
        check("single_idle_done", done, 0);

        pulse_rst();
        for (int i = 0; i < 4; i++) req_data[i*8 +: 8] = vals[i];
        req = 4'b1111;
        for (int k = 0; k < 4; k++) begin
            wait_done(who, res, lat);
            check("cont_who", who, k);
            check("cont_res", res, exps[k]);
            if (who >= 0) req[who] = 1'b0;
        end

        req_data[7:0] = 8'd7;
        req_data[23:16] = 8'd42;
        req = 4'b0101;
        for (int k = 0; k < 4; k++) begin
            wait_done(who, res, lat);
            check("fair_who", who, (k % 2) * 2);
            check("fair_res", res, (k % 2) ? 16'h0042 : 16'h0007);
        end
        req = '0;

        stale = 2;
        req_data[15:8] = 8'd200;
        req = 4'b0010;
        wait_done(who, res, lat);
        check("stale_who", who, 1);
        check("stale_res", res, 16'h0200);
        req = '0;
        stale = 0;
        repeat (3) @(negedge clk);

        req_data[7:0] = 8'd5;
        req = 4'b0001;
        @(negedge clk);
        check("rstmid_gnt", gnt, 4'b0001);
        repeat (8) @(negedge clk);
        check("rstmid_busy_before", busy, 1);
        rst = 1'b1;
        req = '0;
        @(negedge clk);
        rst = 1'b0;
        check("rstmid_gnt_after", gnt, 0);
        check("rstmid_busy_after", busy, 0);
        check("rstmid_done_after", done, 0);
        check("rstmid_result", result, 0);
        d0 = done_cnt;
        repeat (25) @(negedge clk);
        check("rstmid_no_done", done_cnt - d0, 0);
        req_data[31:24] = 8'd77;
        req = 4'b1000;
        wait_done(who, res, lat);
        check("rstmid_who", who, 3);
        check("rstmid_res", res, 16'h0077);
        req = '0;
        repeat (3) @(negedge clk);

`ifdef ARB_TIMEOUT_EN
        stuck = 1;
        req_data[7:0] = 8'd9;
        req = 4'b0001;
        @(negedge clk);
        wait_done(who, res, lat);
        check("to_who", who, 0);
        check("to_flag", timeout, 1);
        check("to_res", res, 16'hFFFF);
        check("to_lat", lat, 65);
        req = '0;
        stuck = 0;
        @(negedge clk);
        check("to_clear", timeout, 0);
        check("to_pulses", to_cnt, 1);
`else
        check("no_timeout", to_cnt, 0);
`endif

        check("gnt_onehot", bad_oh, 0);
        check("gnt_held", bad_hold, 0);
        check("done_onehot", bad_done, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
